// File: rtl/trap_ctrl_pkg.sv
// Shared trap encodings: the cause codes and the trap sequencer state encodings.
package trap_ctrl_pkg;

    localparam logic [31:0] TRAP_CAUSE_IRQ     = 32'h0000_0001;
    localparam logic [31:0] TRAP_CAUSE_ILLEGAL = 32'h0000_0002;
    localparam logic [31:0] TRAP_CAUSE_ECALL   = 32'h0000_0008;
    localparam logic        TRAP_MIE_RESET     = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FLUSH    = 3'd1;
    localparam logic [2:0] ST_REDIRECT = 3'd2;
    localparam logic [2:0] ST_HANDLER  = 3'd3;
    localparam logic [2:0] ST_RETURN   = 3'd4;

    // RETURN is deliberately excluded: the handler is already being left.
    function automatic logic is_trap_state(input logic [2:0] st);
        return (st == ST_FLUSH) || (st == ST_REDIRECT) || (st == ST_HANDLER);
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Purpose: fixed-priority trap source encoder (illegal > ecall > irq).
// Latency: purely combinational, same cycle.
// Backpressure: stall_ex suppresses the candidate; nothing is held here.
module trap_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] CAUSE_IRQ     = TRAP_CAUSE_IRQ,
    parameter logic [31:0] CAUSE_ILLEGAL = TRAP_CAUSE_ILLEGAL,
    parameter logic [31:0] CAUSE_ECALL   = TRAP_CAUSE_ECALL
) (
    input  logic        ex_valid,
    input  logic        stall_ex,
    input  logic        illegal_ex,
    input  logic        ecall_ex,
    input  logic        ext_irq,
    input  logic        mie,
    output logic        cand,
    output logic [31:0] cause,
    output logic        irq_sel
);

    logic live;
    logic irq_live;

    assign live     = ex_valid && !stall_ex;
    assign irq_live = ext_irq && mie;

    always_comb begin
        cand    = 1'b0;
        cause   = 32'h0;
        irq_sel = 1'b0;
        if (live) begin
            if (illegal_ex) begin
                cand  = 1'b1;
                cause = CAUSE_ILLEGAL;
            end else if (ecall_ex) begin
                cand  = 1'b1;
                cause = CAUSE_ECALL;
            end else if (irq_live) begin
                cand    = 1'b1;
                cause   = CAUSE_IRQ;
                irq_sel = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Purpose: trap entry / MRET sequencer beside EX, owning MIE/MPIE/SEPC/SCAUSE.
// Latency: candidate at N -> flush at N+1 -> npc_int at N+2; MRET -> mret+flush at N+1.
// Backpressure: stall_ex defers recognition; ext_irq must be held until irq_ack.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] CAUSE_IRQ     = TRAP_CAUSE_IRQ,
    parameter logic [31:0] CAUSE_ILLEGAL = TRAP_CAUSE_ILLEGAL,
    parameter logic [31:0] CAUSE_ECALL   = TRAP_CAUSE_ECALL,
    parameter logic        MIE_RESET     = TRAP_MIE_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_ex,
    input  logic        ex_valid,
    input  logic        stall_ex,
    input  logic        illegal_ex,
    input  logic        ecall_ex,
    input  logic        mret_ex,
    input  logic        ext_irq,
    output logic [31:0] sepc,
    output logic [31:0] scause,
    output logic        npc_int,
    output logic        mret,
    output logic        flush,
    output logic        irq_ack,
    output logic        mie,
    output logic        in_trap
);

    logic [2:0]  state;
    logic        mpie;
    logic        cand;
    logic [31:0] cause;
    logic        irq_sel;
    logic        ret_req;

    trap_prio_enc #(
        .CAUSE_IRQ     (CAUSE_IRQ),
        .CAUSE_ILLEGAL (CAUSE_ILLEGAL),
        .CAUSE_ECALL   (CAUSE_ECALL)
    ) u_prio (
        .ex_valid   (ex_valid),
        .stall_ex   (stall_ex),
        .illegal_ex (illegal_ex),
        .ecall_ex   (ecall_ex),
        .ext_irq    (ext_irq),
        .mie        (mie),
        .cand       (cand),
        .cause      (cause),
        .irq_sel    (irq_sel)
    );

    // Any trap candidate outranks MRET, so illegal+mret never returns.
    assign ret_req = mret_ex && ex_valid && !stall_ex && !cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sepc    <= 32'h0;
            scause  <= 32'h0;
            mie     <= MIE_RESET;
            mpie    <= 1'b0;
            irq_ack <= 1'b0;
        end else begin
            irq_ack <= 1'b0;
            case (state)
                ST_IDLE, ST_HANDLER: begin
                    if (cand) begin
                        state   <= ST_FLUSH;
                        sepc    <= pc_ex;
                        scause  <= cause;
                        mpie    <= mie;
                        mie     <= 1'b0;
                        irq_ack <= irq_sel;
                    end else if (ret_req) begin
                        state <= ST_RETURN;
                    end
                end
                ST_FLUSH:    state <= ST_REDIRECT;
                ST_REDIRECT: state <= ST_HANDLER;
                ST_RETURN: begin
                    mie   <= mpie;
                    mpie  <= 1'b1;
                    state <= ST_IDLE;
                end
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Moore decode keeps npc_int and mret mutually exclusive by construction.
    assign flush   = (state == ST_FLUSH) || (state == ST_RETURN);
    assign npc_int = (state == ST_REDIRECT);
    assign mret    = (state == ST_RETURN);
    assign in_trap = is_trap_state(state);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed-vector bench for trap_ctrl with hand-computed expectations.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_ex;
    logic        ex_valid, stall_ex, illegal_ex, ecall_ex, mret_ex, ext_irq;
    logic [31:0] sepc, scause;
    logic        npc_int, mret, flush, irq_ack, mie, in_trap;

    int errors = 0;
    int checks = 0;

    trap_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pc_ex      (pc_ex),
        .ex_valid   (ex_valid),
        .stall_ex   (stall_ex),
        .illegal_ex (illegal_ex),
        .ecall_ex   (ecall_ex),
        .mret_ex    (mret_ex),
        .ext_irq    (ext_irq),
        .sepc       (sepc),
        .scause     (scause),
        .npc_int    (npc_int),
        .mret       (mret),
        .flush      (flush),
        .irq_ack    (irq_ack),
        .mie        (mie),
        .in_trap    (in_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        stall_ex   = 1'b0;
        illegal_ex = 1'b0;
        ecall_ex   = 1'b0;
        mret_ex    = 1'b0;
        ext_irq    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".flush"},   {31'b0, flush},   32'd0);
        check({tag, ".npc_int"}, {31'b0, npc_int}, 32'd0);
        check({tag, ".mret"},    {31'b0, mret},    32'd0);
        check({tag, ".irq_ack"}, {31'b0, irq_ack}, 32'd0);
    endtask

    initial begin
        pc_ex = 32'h0;
        do_reset();
        check_quiet("rst");
        check("rst.sepc",    sepc,              32'h0);
        check("rst.scause",  scause,            32'h0);
        check("rst.mie",     {31'b0, mie},      32'd1);
        check("rst.in_trap", {31'b0, in_trap},  32'd0);

        // Bubble with illegal flag must not trap
        ex_valid = 1'b0; illegal_ex = 1'b1; pc_ex = 32'h50;
        step();
        check("bubble.flush",   {31'b0, flush},   32'd0);
        check("bubble.in_trap", {31'b0, in_trap}, 32'd0);
        idle_inputs();

        // ECALL at 0x100: flush at N+1, npc_int at N+2
        ex_valid = 1'b1; ecall_ex = 1'b1; pc_ex = 32'h100;
        step();
        idle_inputs();
        check("ecall.n1.flush",   {31'b0, flush},   32'd1);
        check("ecall.n1.npc_int", {31'b0, npc_int}, 32'd0);
        check("ecall.sepc",       sepc,             32'h100);
        check("ecall.scause",     scause,           32'h8);
        check("ecall.mie",        {31'b0, mie},     32'd0);
        check("ecall.n1.in_trap", {31'b0, in_trap}, 32'd1);
        check("ecall.irq_ack",    {31'b0, irq_ack}, 32'd0);
        step();
        check("ecall.n2.npc_int", {31'b0, npc_int}, 32'd1);
        check("ecall.n2.flush",   {31'b0, flush},   32'd0);
        check("ecall.n2.mret",    {31'b0, mret},    32'd0);
        step();
        check("ecall.hdl.npc_int", {31'b0, npc_int}, 32'd0);
        check("ecall.hdl.in_trap", {31'b0, in_trap}, 32'd1);

        // Reset asserted while in REDIRECT
        do_reset();
        ex_valid = 1'b1; ecall_ex = 1'b1; pc_ex = 32'h180;
        step();
        idle_inputs();
        step();
        check("rstmid.redirect.npc_int", {31'b0, npc_int}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_quiet("rstmid");
        check("rstmid.mie",     {31'b0, mie},     32'd1);
        check("rstmid.in_trap", {31'b0, in_trap}, 32'd0);
        check("rstmid.sepc",    sepc,             32'h0);
        check("rstmid.scause",  scause,           32'h0);
        step();
        check("rstmid.after.npc_int", {31'b0, npc_int}, 32'd0);
        check("rstmid.after.in_trap", {31'b0, in_trap}, 32'd0);

        // All sources plus mret together: illegal wins, no ack, no mret
        ex_valid = 1'b1; illegal_ex = 1'b1; ecall_ex = 1'b1; ext_irq = 1'b1;
        mret_ex = 1'b1; pc_ex = 32'h200;
        step();
        idle_inputs();
        check("prio.scause",  scause,           32'h2);
        check("prio.sepc",    sepc,             32'h200);
        check("prio.irq_ack", {31'b0, irq_ack}, 32'd0);
        check("prio.mret",    {31'b0, mret},    32'd0);
        check("prio.flush",   {31'b0, flush},   32'd1);
        step();
        check("prio.n2.irq_ack", {31'b0, irq_ack}, 32'd0);
        check("prio.n2.npc_int", {31'b0, npc_int}, 32'd1);

        // ext_irq held under stall for 3 cycles, accepted when stall drops
        do_reset();
        ex_valid = 1'b1; ext_irq = 1'b1; stall_ex = 1'b1; pc_ex = 32'h330;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d.flush", i),   {31'b0, flush},   32'd0);
            check($sformatf("stall%0d.irq_ack", i), {31'b0, irq_ack}, 32'd0);
            check($sformatf("stall%0d.in_trap", i), {31'b0, in_trap}, 32'd0);
        end
        stall_ex = 1'b0; pc_ex = 32'h340;
        step();
        idle_inputs();
        check("irq.irq_ack", {31'b0, irq_ack}, 32'd1);
        check("irq.scause",  scause,           32'h1);
        check("irq.sepc",    sepc,             32'h340);
        check("irq.flush",   {31'b0, flush},   32'd1);
        step();
        check("irq.n2.irq_ack", {31'b0, irq_ack}, 32'd0);
        check("irq.n2.npc_int", {31'b0, npc_int}, 32'd1);
        step();
        check("irq.hdl.mie", {31'b0, mie}, 32'd0);

        // In HANDLER: irq masked, then MRET returns with mie restored
        ex_valid = 1'b1; ext_irq = 1'b1; pc_ex = 32'h400;
        step();
        check("hdl.irq.flush",   {31'b0, flush},   32'd0);
        check("hdl.irq.irq_ack", {31'b0, irq_ack}, 32'd0);
        check("hdl.irq.in_trap", {31'b0, in_trap}, 32'd1);
        check("hdl.irq.sepc",    sepc,             32'h340);
        ext_irq = 1'b0; mret_ex = 1'b1; pc_ex = 32'h404;
        step();
        idle_inputs();
        check("ret.mret",    {31'b0, mret},    32'd1);
        check("ret.flush",   {31'b0, flush},   32'd1);
        check("ret.npc_int", {31'b0, npc_int}, 32'd0);
        step();
        check_quiet("ret.after");
        check("ret.mie",     {31'b0, mie},     32'd1);
        check("ret.in_trap", {31'b0, in_trap}, 32'd0);
        check("ret.sepc",    sepc,             32'h340);
        check("ret.scause",  scause,           32'h1);

        // Re-trap from HANDLER on an illegal instruction
        ex_valid = 1'b1; ecall_ex = 1'b1; pc_ex = 32'h900;
        step();
        idle_inputs();
        step();
        step();
        check("retrap.pre.in_trap", {31'b0, in_trap}, 32'd1);
        ex_valid = 1'b1; illegal_ex = 1'b1; pc_ex = 32'hA80;
        step();
        idle_inputs();
        check("retrap.flush",  {31'b0, flush}, 32'd1);
        check("retrap.sepc",   sepc,           32'hA80);
        check("retrap.scause", scause,         32'h2);
        check("retrap.mie",    {31'b0, mie},   32'd0);
        step();
        check("retrap.npc_int", {31'b0, npc_int}, 32'd1);
        step();
        check("retrap.hdl.mie", {31'b0, mie}, 32'd0);
        // mpie was overwritten with 0 by the nested entry
        ex_valid = 1'b1; mret_ex = 1'b1;
        step();
        idle_inputs();
        check("retrap.ret.mret", {31'b0, mret}, 32'd1);
        step();
        check("retrap.ret.mie", {31'b0, mie}, 32'd0);

        // MRET in IDLE straight after reset: pulse still issued, sepc stays 0
        do_reset();
        ex_valid = 1'b1; mret_ex = 1'b1; pc_ex = 32'h60;
        step();
        idle_inputs();
        check("idlemret.mret",  {31'b0, mret},  32'd1);
        check("idlemret.flush", {31'b0, flush}, 32'd1);
        check("idlemret.sepc",  sepc,           32'h0);
        step();
        check("idlemret.after.mret", {31'b0, mret}, 32'd0);
        check("idlemret.mie",        {31'b0, mie},  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
